smpl_circuit_pipe: RTL and testbench
====================================

Name: smpl_circuit_pipe

Overview:
Parametrised, pipelined, multi-channel successor to the three-input gate circuit.
- Evaluates CH independent (a,b,c) bit-triples per transfer, using one of four selectable gate functions.
- Moves data through a 2-stage valid/ready pipeline.
- Keeps a saturating count of asserted x outputs.
- Sits between the tt_um top-level pin mapping and the user logic; replaces the purely combinational gate block.

Parameters:
CH, 4, number of independent channels (1..8)
CNT_W, 8, width of the x-assertion event counter (4..16)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input triple bus valid
in_ready  out  1  block can accept input this cycle
a  in  CH  channel A bits
b  in  CH  channel B bits
c  in  CH  channel C bits
mode  in  2  gate-function select, sampled with the data
out_valid  out  1  x/y hold a valid result
out_ready  in  1  downstream accepts result
x  out  CH  primary result per channel
y  out  CH  secondary result per channel
clr_count  in  1  synchronous clear of x_count
x_count  out  CNT_W  saturating count of x bits delivered

Behaviour:
- Reset is asynchronous on rst_n low. Outputs go to: in_ready=1 once s1 is empty (combinational), out_valid=0, x=0, y=0, x_count=0. All stage valid flags go to 0.
- Stage 1 (s1) registers a, b, c and mode on input handshake (in_valid & in_ready).
- Stage 2 (s2) registers the computed x/y from s1 when s1 is valid and s2 can advance.
- s2 can advance when s2 is empty or out_ready=1. out_valid is s2's valid flag.
- in_ready = !s1_v | (s2 empty | out_ready). It is combinational; there is no skid buffer. Full throughput is 1 transfer/cycle when out_ready stays high.
- Latency: data accepted on edge n is presented on x/y with out_valid=1 after edge n+1.
- Holding under backpressure: x/y/out_valid hold stable while out_valid & !out_ready. The s1 contents hold while blocked.
- The s1 valid flag follows:
  - It clears when s1 drains into s2 with no new input.
  - A simultaneous drain and accept on the same edge is legal and keeps s1 valid with the new data.
- Mode functions, bitwise per channel i, using the mode value captured with that beat:
  - 00: x=(a&b)|~c, y=~c (legacy function)
  - 01: x=(a|b)&c, y=c
  - 10: x=a^b^c, y=(a&b)|(c&(a^b)) (full-adder sum/carry)
  - 11: x=a&b&c, y=~(a|b|c)
- mode changes while data is in flight do not affect beats already accepted.
- x_count update on each output handshake (out_valid & out_ready):
  - x_count += popcount(x), computed CNT_W+4 bits wide.
  - The result saturates at 2^CNT_W-1 and never wraps.
- clr_count=1 forces x_count to 0 on the next edge. It takes priority over a simultaneous handshake increment; that transfer's bits are discarded.
- Reset mid-transfer discards all in-flight beats. The first beat after reset release is handled normally.
- in_valid with in_ready=0 causes no state change. The source must hold its data; the block does not check this.

Optional Feature:
- Macro: SMPL_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit) = ^{x,y} of the s2 beat.
  - It is registered together with x/y in stage 2, resets to 0, and holds under backpressure like x/y.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset and mode 00 sweep (CH=4): hold rst_n low, then release. Send mode=00, a=4'b1010, b=4'b1100, c=4'b0110.
  - Required: after edge n+1, x=4'b1001, y=4'b1001, out_valid=1. Then x_count=2.
- Mode 10 full adder: send a=4'b1111, b=4'b0101, c=4'b0011. Required: x=4'b1001, y=4'b0111.
- Backpressure: stream 3 beats with out_ready=0 for 4 cycles.
  - Required: in_ready=0 after 2 beats are accepted; x/y stable; no beat lost or duplicated.
  - When out_ready rises, all 3 beats emerge in order.
- Full throughput: in_valid=1 and out_ready=1 for 10 cycles, mode toggling each beat. Required: 10 results on consecutive cycles, each using its own mode.
- Saturation and clear with CNT_W=4:
  - Send 4 beats in mode 11 with a=b=c=4'hF (popcount 4 each). Required: x_count=15 (saturated, not 0).
  - Then assert clr_count together with a handshake. Required: x_count=0.
- Reset mid-flight: assert rst_n=0 while s1 and s2 are both valid. Required: out_valid=0 and x=y=0 immediately, without waiting for a clock edge; x_count=0.

Source files
------------

// File: rtl/smpl_circuit_pipe.sv
// Two-stage valid/ready pipeline evaluating CH three-input gate functions per beat, with a saturating x-bit counter.
// Latency 2 edges from accept to x/y; in_ready drops only when s1 is full and s2 is stalled. Optional SMPL_PARITY_EN adds out_par.
module smpl_circuit_pipe #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH-1:0]    a,
    input  logic [CH-1:0]    b,
    input  logic [CH-1:0]    c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH-1:0]    x,
    output logic [CH-1:0]    y,
    input  logic             clr_count,
`ifdef SMPL_PARITY_EN
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] x_count
);

    localparam logic [CNT_W+3:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

    logic             s1_v_q, s1_v_d;
    logic [CH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
    logic [1:0]       mode_q, mode_d;
    logic             s2_v_q, s2_v_d;
    logic [CH-1:0]    x_q, x_d, y_q, y_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_adv, accept, out_hs;
    logic [CH-1:0]    fx, fy;
    logic [CNT_W+3:0] pop, sum;

    assign s2_adv    = !s2_v_q || out_ready;
    assign in_ready  = !s1_v_q || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_hs    = s2_v_q && out_ready;
    assign out_valid = s2_v_q;
    assign x         = x_q;
    assign y         = y_q;
    assign x_count   = cnt_q;
`ifdef SMPL_PARITY_EN
    assign out_par   = par_q;
`endif

    // Gate function uses the mode captured with the beat, not the live input.
    always_comb begin
        fx = '0;
        fy = '0;
        case (mode_q)
            2'b00: begin fx = (a_q & b_q) | ~c_q;  fy = ~c_q;                                 end
            2'b01: begin fx = (a_q | b_q) & c_q;   fy = c_q;                                  end
            2'b10: begin fx = a_q ^ b_q ^ c_q;     fy = (a_q & b_q) | (c_q & (a_q ^ b_q));    end
            default: begin fx = a_q & b_q & c_q;   fy = ~(a_q | b_q | c_q);                   end
        endcase
    end

    always_comb begin
        s1_v_d = s1_v_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        mode_d = mode_q;
        if (accept) begin
            s1_v_d = 1'b1;
            a_d    = a;
            b_d    = b;
            c_d    = c;
            mode_d = mode;
        end else if (s1_v_q && s2_adv) begin
            s1_v_d = 1'b0;
        end

        s2_v_d = s2_v_q;
        x_d    = x_q;
        y_d    = y_q;
        par_d  = par_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                x_d   = fx;
                y_d   = fy;
                par_d = ^{fx, fy};
            end
        end
    end

    // Sum is computed 4 bits wider so a full-width popcount can never wrap before the clamp.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CH; i++) begin
            pop = pop + {{(CNT_W+3){1'b0}}, x_q[i]};
        end
        sum   = {4'b0000, cnt_q} + pop;
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (out_hs) begin
            cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            mode_q <= '0;
            s2_v_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            par_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            mode_q <= mode_d;
            s2_v_q <= s2_v_d;
            x_q    <= x_d;
            y_q    <= y_d;
            par_q  <= par_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_smpl_circuit_pipe.sv
// Directed bench for smpl_circuit_pipe (CH=4, CNT_W=4) with hand-computed expectations.
module tb_smpl_circuit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b, c;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] x, y;
    logic       clr_count;
    logic [3:0] x_count;
`ifdef SMPL_PARITY_EN
    logic       out_par;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] ex_x [4];
    logic [3:0] ex_y [4];

    smpl_circuit_pipe #(.CH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .clr_count (clr_count),
`ifdef SMPL_PARITY_EN
        .out_par   (out_par),
`endif
        .x_count   (x_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc);
        in_valid = 1'b1;
        mode     = m;
        a        = va;
        b        = vb;
        c        = vc;
    endtask

    initial begin
        // Expected results for a=1010 b=1100 c=0110 under each mode
        ex_x[0] = 4'b1001; ex_y[0] = 4'b1001;
        ex_x[1] = 4'b0110; ex_y[1] = 4'b0110;
        ex_x[2] = 4'b0000; ex_y[2] = 4'b1110;
        ex_x[3] = 4'b0000; ex_y[3] = 4'b0001;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
        mode = 2'b00; a = '0; b = '0; c = '0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_x", x, 4'h0);
        chk("rst_y", y, 4'h0);
        chk("rst_count", x_count, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        step(); step();
        rst_n = 1'b1;

        // Mode 00 single beat
        out_ready = 1'b1;
        drive(2'b00, 4'b1010, 4'b1100, 4'b0110);
        step();
        in_valid = 1'b0;
        chk("m00_s1_only", out_valid, 1'b0);
        step();
        chk("m00_valid", out_valid, 1'b1);
        chk("m00_x", x, 4'b1001);
        chk("m00_y", y, 4'b1001);
        step();
        chk("m00_count", x_count, 4'd2);
        chk("m00_drained", out_valid, 1'b0);

        // Mode 10 full adder
        drive(2'b10, 4'b1111, 4'b0101, 4'b0011);
        step();
        in_valid = 1'b0;
        step();
        chk("fa_valid", out_valid, 1'b1);
        chk("fa_sum", x, 4'b1001);
        chk("fa_carry", y, 4'b0111);
        step();
        chk("fa_count", x_count, 4'd4);

        // Backpressure: three beats with out_ready low
        out_ready = 1'b0;
        drive(2'b00, 4'b1010, 4'b1100, 4'b0110);
        step();
        chk("bp_ready_1", in_ready, 1'b1);
        drive(2'b01, 4'b0011, 4'b0101, 4'b1110);
        step();
        chk("bp_ready_2", in_ready, 1'b0);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_x0", x, 4'b1001);
        drive(2'b11, 4'b1111, 4'b0111, 4'b0101);
        step();
        chk("bp_hold_x", x, 4'b1001);
        chk("bp_hold_y", y, 4'b1001);
        chk("bp_hold_ready", in_ready, 1'b0);
        step(); step();
        chk("bp_hold_x2", x, 4'b1001);
        chk("bp_hold_v2", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_b1_x", x, 4'b0110);
        chk("bp_b1_y", y, 4'b1110);
        step();
        chk("bp_b2_x", x, 4'b0101);
        chk("bp_b2_y", y, 4'b0000);
        chk("bp_b2_valid", out_valid, 1'b1);
        step();
        chk("bp_empty", out_valid, 1'b0);
        chk("bp_count", x_count, 4'd10);

        // Full throughput with mode toggling every beat
        for (int i = 0; i < 10; i++) begin
            drive(2'(i % 4), 4'b1010, 4'b1100, 4'b0110);
            step();
            if (i >= 1) begin
                chk("ft_valid", out_valid, 1'b1);
                chk("ft_x", x, ex_x[(i-1) % 4]);
                chk("ft_y", y, ex_y[(i-1) % 4]);
            end
            chk("ft_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        step();
        chk("ft_last_valid", out_valid, 1'b1);
        chk("ft_last_x", x, ex_x[1]);
        step();
        chk("ft_count_sat", x_count, 4'd15);

        // Clear, then saturate with popcount-4 beats
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_zero", x_count, 4'd0);
        drive(2'b11, 4'hF, 4'hF, 4'hF);
        step(); step(); step(); step();
        in_valid = 1'b0;
        step();
        chk("sat_12", x_count, 4'd12);
        step();
        chk("sat_15", x_count, 4'd15);
        drive(2'b11, 4'hF, 4'hF, 4'hF);
        step();
        in_valid = 1'b0;
        step();
        chk("clr_hs_valid", out_valid, 1'b1);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_priority", x_count, 4'd0);

        // Reset mid-flight with s1 and s2 both full
        out_ready = 1'b0;
        drive(2'b00, 4'b1010, 4'b1100, 4'b0110);
        step();
        drive(2'b10, 4'b1111, 4'b0101, 4'b0011);
        step();
        in_valid = 1'b0;
        chk("mid_full_ready", in_ready, 1'b0);
        chk("mid_x_before", x, 4'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_x", x, 4'h0);
        chk("mid_rst_y", y, 4'h0);
        chk("mid_rst_count", x_count, 4'h0);
        chk("mid_rst_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_idle", out_valid, 1'b0);
        drive(2'b10, 4'b1111, 4'b0101, 4'b0011);
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_x", x, 4'b1001);
        chk("post_rst_y", y, 4'b0111);
        step();
        chk("post_rst_count", x_count, 4'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
